// File: rtl/board_rst_sequencer.sv
// Board power-up/reset sequencer: debounces the reset button, waits for PLL lock and DDR calibration,
// then releases Ethernet, peripheral and core resets in order. Optional calibration watchdog: RST_SEQ_CAL_TIMEOUT_EN.
module board_rst_sequencer #(
    parameter int DEBOUNCE_CYCLES    = 100000,
    parameter int ETH_RST_CYCLES     = 1000,
    parameter int SETTLE_CYCLES      = 500,
    parameter int NDM_MIN_CYCLES     = 16,
    parameter int CAL_TIMEOUT_CYCLES = 10000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       button_ni,
    input  logic       pll_locked_i,
    input  logic       ddr_calib_done_i,
    input  logic       ndmreset_i,
    output logic       eth_rst_no,
    output logic       sd_reset_o,
    output logic       periph_rst_no,
    output logic       core_rst_no,
    output logic       calib_timeout_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_WAIT_CAL = 3'd1,
        S_ETH_RST  = 3'd2,
        S_SETTLE   = 3'd3,
        S_RUN      = 3'd4,
        S_CORE_RST = 3'd5
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_BASE = max2(max2(ETH_RST_CYCLES, SETTLE_CYCLES), NDM_MIN_CYCLES);
`ifdef RST_SEQ_CAL_TIMEOUT_EN
    localparam int CNT_LIMIT = max2(CNT_BASE, CAL_TIMEOUT_CYCLES);
`else
    localparam int CNT_LIMIT = CNT_BASE;
`endif
    localparam int CNT_W = (CNT_LIMIT > 1) ? $clog2(CNT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_LIMIT - 1);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if (DEBOUNCE_CYCLES < 1 || ETH_RST_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        NDM_MIN_CYCLES < 1 || CAL_TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("board_rst_sequencer: all cycle parameters must be >= 1");
    end

    // Synchronizers reset to 0, so the button reads as pressed until it has been seen released.
    logic [1:0] btn_sync_q, pll_sync_q, cal_sync_q;
    logic       btn_s, pll_s, cal_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync_q <= 2'b00;
            pll_sync_q <= 2'b00;
            cal_sync_q <= 2'b00;
        end else begin
            btn_sync_q <= {btn_sync_q[0], button_ni};
            pll_sync_q <= {pll_sync_q[0], pll_locked_i};
            cal_sync_q <= {cal_sync_q[0], ddr_calib_done_i};
        end
    end

    assign btn_s = btn_sync_q[1];
    assign pll_s = pll_sync_q[1];
    assign cal_s = cal_sync_q[1];

    logic            db_q, db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (btn_s != db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_q     <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort;
    logic             late_state;
`ifdef RST_SEQ_CAL_TIMEOUT_EN
    logic             timeout_set;
`endif

    assign late_state = (state_q == S_ETH_RST) || (state_q == S_SETTLE) ||
                        (state_q == S_RUN) || (state_q == S_CORE_RST);
    assign abort      = !db_q || !pll_s || (late_state && !cal_s);

    always_comb begin
        state_d = state_q;
`ifdef RST_SEQ_CAL_TIMEOUT_EN
        timeout_set = 1'b0;
`endif
        if (abort) begin
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_HOLD:     state_d = S_WAIT_CAL;
                S_WAIT_CAL: begin
                    if (cal_s) begin
                        state_d = S_ETH_RST;
`ifdef RST_SEQ_CAL_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(CAL_TIMEOUT_CYCLES - 1)) begin
                        state_d     = S_HOLD;
                        timeout_set = 1'b1;
`endif
                    end
                end
                S_ETH_RST:  if (cnt_q == CNT_W'(ETH_RST_CYCLES - 1)) state_d = S_SETTLE;
                S_SETTLE:   if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = S_RUN;
                S_RUN:      if (ndmreset_i) state_d = S_CORE_RST;
                S_CORE_RST: if (!ndmreset_i && cnt_q >= CNT_W'(NDM_MIN_CYCLES - 1)) state_d = S_RUN;
                default:    state_d = S_HOLD;
            endcase
        end
        // Shared counter restarts on every transition and saturates so long waits never wrap.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    logic eth_d, sd_d, periph_d, core_d;

    always_comb begin
        eth_d    = 1'b0;
        sd_d     = 1'b1;
        periph_d = 1'b0;
        core_d   = 1'b0;
        case (state_d)
            S_SETTLE:   begin eth_d = 1'b1; sd_d = 1'b0; periph_d = 1'b1; end
            S_RUN:      begin eth_d = 1'b1; sd_d = 1'b0; periph_d = 1'b1; core_d = 1'b1; end
            S_CORE_RST: begin eth_d = 1'b1; sd_d = 1'b0; periph_d = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            eth_rst_no    <= 1'b0;
            sd_reset_o    <= 1'b1;
            periph_rst_no <= 1'b0;
            core_rst_no   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            eth_rst_no    <= eth_d;
            sd_reset_o    <= sd_d;
            periph_rst_no <= periph_d;
            core_rst_no   <= core_d;
        end
    end

`ifdef RST_SEQ_CAL_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end
    end

    assign calib_timeout_o = timeout_q;
`else
    assign calib_timeout_o = 1'b0;
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_board_rst_sequencer.sv
// Randomized bench for board_rst_sequencer against a phase/timer reference model.
module tb_board_rst_sequencer;

    localparam int DB  = 4;
    localparam int ETH = 8;
    localparam int SET = 5;
    localparam int NDM = 3;
    localparam int CAL = 50;
`ifdef RST_SEQ_CAL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       button_ni, pll_locked_i, ddr_calib_done_i, ndmreset_i;
    logic       eth_rst_no, sd_reset_o, periph_rst_no, core_rst_no, calib_timeout_o;
    logic [2:0] state_o;

    board_rst_sequencer #(
        .DEBOUNCE_CYCLES(DB), .ETH_RST_CYCLES(ETH), .SETTLE_CYCLES(SET),
        .NDM_MIN_CYCLES(NDM), .CAL_TIMEOUT_CYCLES(CAL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .button_ni(button_ni), .pll_locked_i(pll_locked_i),
        .ddr_calib_done_i(ddr_calib_done_i), .ndmreset_i(ndmreset_i),
        .eth_rst_no(eth_rst_no), .sd_reset_o(sd_reset_o), .periph_rst_no(periph_rst_no),
        .core_rst_no(core_rst_no), .calib_timeout_o(calib_timeout_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int state_len[8];
    int core_low;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase number, countdown for fixed-length phases, age for minimum-length phases.
    int m_phase, m_left, m_age;
    bit m_db, m_to;
    bit btn_q[$], pll_q[$], cal_q[$], hist[$];

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_age = 1; m_db = 1'b0; m_to = 1'b0;
        btn_q = '{1'b0, 1'b0}; pll_q = '{1'b0, 1'b0}; cal_q = '{1'b0, 1'b0};
        hist.delete();
    endtask

    task automatic go(input int p);
        m_phase = p;
        m_age   = 1;
        m_left  = (p == 2) ? ETH : (p == 3) ? SET : 0;
    endtask

    task automatic model_step();
        bit bs, ps, cs, all_new;
        bs = btn_q[0]; ps = pll_q[0]; cs = cal_q[0];
        if (!m_db || !ps || (m_phase >= 2 && !cs)) begin
            go(0);
        end else begin
            case (m_phase)
                0: go(1);
                1: begin
                    if (cs) go(2);
                    else if (TO_EN && m_age >= CAL) begin m_to = 1'b1; go(0); end
                    else m_age++;
                end
                2: begin m_left--; if (m_left == 0) go(3); end
                3: begin m_left--; if (m_left == 0) go(4); end
                4: if (ndmreset_i) go(5);
                5: begin
                    if (!ndmreset_i && m_age >= NDM) go(4);
                    else m_age++;
                end
                default: go(0);
            endcase
        end
        // Debounced level follows the synced button once its last DB samples all disagree with it.
        hist.push_back(bs);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB) begin
            all_new = 1'b1;
            foreach (hist[i]) if (hist[i] == m_db) all_new = 1'b0;
            if (all_new) m_db = bs;
        end
        void'(btn_q.pop_front()); btn_q.push_back(button_ni);
        void'(pll_q.pop_front()); pll_q.push_back(pll_locked_i);
        void'(cal_q.pop_front()); cal_q.push_back(ddr_calib_done_i);
    endtask

    function automatic logic [3:0] exp_out(input int p);
        case (p)
            3, 5:    return 4'b1010;
            4:       return 4'b1011;
            default: return 4'b0100;
        endcase
    endfunction

    task automatic compare_all();
        logic [3:0] e;
        e = exp_out(m_phase);
        check("state", int'(state_o), m_phase);
        check("eth_rst_no", int'(eth_rst_no), int'(e[3]));
        check("sd_reset_o", int'(sd_reset_o), int'(e[2]));
        check("periph_rst_no", int'(periph_rst_no), int'(e[1]));
        check("core_rst_no", int'(core_rst_no), int'(e[0]));
        check("calib_timeout_o", int'(calib_timeout_o), int'(m_to));
        state_len[state_o]++;
        if (!core_rst_no) core_low++;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_ni) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until(input string tag, input int phase, input int budget);
        for (int i = 0; i < budget && m_phase != phase; i++) cycle();
        check(tag, int'(state_o), phase);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_ni = 1'b1;
    endtask

    initial begin
        int len;
        rst_ni = 1'b0; button_ni = 1'b1; pll_locked_i = 1'b1;
        ddr_calib_done_i = 1'b1; ndmreset_i = 1'b0;
        do_reset();

        // Power-up: measure ETH_RST and SETTLE lengths from the outputs.
        foreach (state_len[i]) state_len[i] = 0;
        run_until("powerup_run", 4, 100);
        check("eth_rst_len", state_len[2], ETH);
        check("settle_len", state_len[3], SET);
        repeat (3) cycle();

        // Debounce: short glitches are filtered, a long press restarts the sequence.
        for (int g = 0; g < 3; g++) begin
            button_ni = 1'b0;
            repeat ($urandom_range(1, DB - 1)) cycle();
            button_ni = 1'b1;
            repeat (6) cycle();
            check("glitch_run", int'(state_o), 4);
        end
        button_ni = 1'b0;
        repeat ($urandom_range(DB + 3, DB + 8)) cycle();
        check("press_hold", int'(state_o), 0);
        button_ni = 1'b1;
        run_until("press_rerun", 4, 100);

        // ndmreset pulses of random width.
        for (int p = 0; p < 5; p++) begin
            len = (p == 0) ? 1 : (p == 1) ? 10 : $urandom_range(1, 12);
            core_low = 0;
            ndmreset_i = 1'b1;
            repeat (len) cycle();
            ndmreset_i = 1'b0;
            repeat (NDM + 3) cycle();
            check("ndm_low_len", core_low, (len > NDM) ? len : NDM);
        end

        // Mid-sequence PLL loss during SETTLE.
        pll_locked_i = 1'b0;
        repeat (5) cycle();
        pll_locked_i = 1'b1;
        run_until("reach_settle", 3, 100);
        pll_locked_i = 1'b0;
        repeat (4) cycle();
        check("pll_abort", int'(state_o), 0);
        pll_locked_i = 1'b1;
        run_until("pll_rerun", 4, 100);

        // Calibration held low: watchdog retries when enabled, waits otherwise.
        ddr_calib_done_i = 1'b0;
        repeat (3 * CAL) cycle();
        check("cal_wait_flag", int'(calib_timeout_o), int'(TO_EN));
        ddr_calib_done_i = 1'b1;
        run_until("cal_rerun", 4, 150);
        check("cal_sticky", int'(calib_timeout_o), int'(TO_EN));

        // Random soak.
        for (int i = 0; i < 1500; i++) begin
            button_ni        = button_ni ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 3) == 0);
            pll_locked_i     = pll_locked_i ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 9) == 0);
            ddr_calib_done_i = ddr_calib_done_i ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 19) == 0);
            ndmreset_i       = ($urandom_range(0, 19) == 0) || (ndmreset_i && $urandom_range(0, 2) != 0);
            cycle();
        end

        // Async reset from RUN, checked before any clock edge.
        button_ni = 1'b1; pll_locked_i = 1'b1; ddr_calib_done_i = 1'b1; ndmreset_i = 1'b0;
        run_until("pre_async_run", 4, 200);
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        run_until("post_async_run", 4, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
